// File: rtl/instr_pkg.sv
// Shared encoding constants for the instruction encoder: ALU op codes,
// opcode/funct values, instruction field positions and default queue depth.
package instr_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ENTRY_W        = WORD_W + 1;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd6,
    OP_SLT = 4'd7,
    OP_NOR = 4'd12
  } op_e;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;

  localparam int unsigned F_OP_LSB = 26;
  localparam int unsigned F_RS_LSB = 21;
  localparam int unsigned F_RT_LSB = 16;
  localparam int unsigned F_RD_LSB = 11;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding {err, instr} entries; exposes occupancy count.
// The read port drives zero whenever the queue is empty.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  assign rdata = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU field sets into R/I-type instruction words, queued through
// instr_fifo; unencodable sets queue a zero word flagged with out_err.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             ssel,
  input  logic [31:0]      imm,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rdst_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      word;
  logic             err;
  logic [5:0]       funct;
  logic [5:0]       opc;
  logic             imm_ok;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  always_comb begin
    word   = '0;
    err    = 1'b1;
    funct  = '0;
    opc    = '0;
    imm_ok = 1'b0;
    if (ssel) begin
      case (op)
        OP_AND:  begin funct = FUNCT_AND; err = 1'b0; end
        OP_OR:   begin funct = FUNCT_OR;  err = 1'b0; end
        OP_ADD:  begin funct = FUNCT_ADD; err = 1'b0; end
        OP_SUB:  begin funct = FUNCT_SUB; err = 1'b0; end
        OP_SLT:  begin funct = FUNCT_SLT; err = 1'b0; end
        OP_NOR:  begin funct = FUNCT_NOR; err = 1'b0; end
        default: ;
      endcase
      if (!err) begin
        word = (32'(rs1_id) << F_RS_LSB) | (32'(rs2_id) << F_RT_LSB)
             | (32'(rdst_id) << F_RD_LSB) | 32'(funct);
      end
    end else begin
      // Signed immediates must fit 16 bits; logical ones are zero-extended.
      case (op)
        OP_ADD:  begin opc = OPC_ADDI; imm_ok = (&imm[31:15]) | ~(|imm[31:15]); end
        OP_SLT:  begin opc = OPC_SLTI; imm_ok = (&imm[31:15]) | ~(|imm[31:15]); end
        OP_AND:  begin opc = OPC_ANDI; imm_ok = ~(|imm[31:16]); end
        OP_OR:   begin opc = OPC_ORI;  imm_ok = ~(|imm[31:16]); end
        default: ;
      endcase
      err = ~imm_ok;
      if (imm_ok) begin
        word = (32'(opc) << F_OP_LSB) | (32'(rs1_id) << F_RS_LSB)
             | (32'(rdst_id) << F_RT_LSB) | 32'(imm[15:0]);
      end
    end
  end

  assign in_ready  = rst && (occ < OCC_W'(FIFO_DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({err, word}),
    .rdata ({out_err, instr}),
    .count (occ)
  );

  always_comb begin
    enc_count_d = enc_count_q;
    if (!rst) begin
      enc_count_d = '0;
    end else if (push && !err && (enc_count_q != '1)) begin
      enc_count_d = enc_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    enc_count_q <= enc_count_d;
  end

  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic        ssel;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;

  logic        in_ready, out_valid, out_err;
  logic [31:0] instr;
  logic [15:0] enc_count;
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_instr;
  logic [3:0]  s_enc_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  instr_encoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ssel(ssel), .imm(imm), .rs1_id(rs1), .rs2_id(rs2), .rdst_id(rd),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .out_err(out_err), .enc_count(enc_count)
  );

  instr_encoder #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .ssel(ssel), .imm(imm), .rs1_id(rs1), .rs2_id(rs2), .rdst_id(rd),
    .out_valid(s_out_valid), .out_ready(out_ready), .instr(s_instr),
    .out_err(s_out_err), .enc_count(s_enc_count)
  );

  typedef struct {
    logic [31:0] word;
    logic        err;
    logic [3:0]  op;
    logic        ssel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
  } ent_t;

  ent_t        q[$];
  int unsigned cnt = 0;
  int unsigned cnt4 = 0;
  bit          fresh = 1'b1;
  bit          m_pop, m_push;
  ent_t        m_e, d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
  endtask

  function automatic ent_t mk(input logic [3:0] o, input logic s, input logic [31:0] im,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] dd);
    ent_t e;
    logic [5:0] f;
    bit ok;
    int sv;
    e.op = o; e.ssel = s; e.imm = im; e.rs1 = a; e.rs2 = b; e.rd = dd;
    e.word = 32'h0; e.err = 1'b1;
    ok = 1'b1; f = 6'h00;
    sv = $signed(im);
    if (s) begin
      case (o)
        4'd0: f = 6'h24;  4'd1: f = 6'h25;  4'd2: f = 6'h20;
        4'd6: f = 6'h22;  4'd7: f = 6'h2A;  4'd12: f = 6'h27;
        default: ok = 1'b0;
      endcase
      if (ok) begin e.word = {6'h00, a, b, dd, 5'h00, f}; e.err = 1'b0; end
    end else begin
      case (o)
        4'd2: begin f = 6'h08; ok = (sv >= -32768) && (sv <= 32767); end
        4'd7: begin f = 6'h0A; ok = (sv >= -32768) && (sv <= 32767); end
        4'd0: begin f = 6'h0C; ok = (im < 32'h10000); end
        4'd1: begin f = 6'h0D; ok = (im < 32'h10000); end
        default: ok = 1'b0;
      endcase
      if (ok) begin e.word = {f, a, dd, im[15:0]}; e.err = 1'b0; end
    end
    return e;
  endfunction

  // Independent decoder used for the round-trip check.
  function automatic ent_t dec(input logic [31:0] w);
    ent_t r;
    r.word = w; r.err = 1'b0; r.imm = 32'h0; r.rs2 = 5'd0; r.rs1 = w[25:21];
    if (w[31:26] == 6'h00) begin
      r.ssel = 1'b1; r.rs2 = w[20:16]; r.rd = w[15:11];
      case (w[5:0])
        6'h24: r.op = 4'd0;  6'h25: r.op = 4'd1;  6'h20: r.op = 4'd2;
        6'h22: r.op = 4'd6;  6'h2A: r.op = 4'd7;  6'h27: r.op = 4'd12;
        default: r.op = 4'd15;
      endcase
    end else begin
      r.ssel = 1'b0; r.rd = w[20:16];
      case (w[31:26])
        6'h08: begin r.op = 4'd2; r.imm = {{16{w[15]}}, w[15:0]}; end
        6'h0A: begin r.op = 4'd7; r.imm = {{16{w[15]}}, w[15:0]}; end
        6'h0C: begin r.op = 4'd0; r.imm = {16'h0, w[15:0]}; end
        6'h0D: begin r.op = 4'd1; r.imm = {16'h0, w[15:0]}; end
        default: r.op = 4'd15;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      cnt = 0; cnt4 = 0; fresh = 1'b1;
    end else begin
      m_pop  = (q.size() != 0) && out_ready;
      m_push = in_valid && (q.size() < 4);
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        m_e = mk(op, ssel, imm, rs1, rs2, rd);
        q.push_back(m_e);
        fresh = 1'b0;
        if (!m_e.err) begin
          if (cnt < 65535) cnt++;
          if (cnt4 < 15) cnt4++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(rst && (q.size() < 4)));
    chk("sat_in_ready", 32'(s_in_ready), 32'(rst && (q.size() < 4)));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("enc_count", 32'(enc_count), cnt);
    chk("sat_enc_count", 32'(s_enc_count), cnt4);
    if (q.size() != 0) begin
      chk("instr", instr, q[0].word);
      chk("out_err", 32'(out_err), 32'(q[0].err));
      chk("sat_instr", s_instr, q[0].word);
      if (!q[0].err) begin
        d = dec(instr);
        chk("rt_fields", 32'({d.op, d.ssel, d.rs1, d.rs2, d.rd}),
            32'({q[0].op, q[0].ssel, q[0].rs1, (q[0].ssel ? q[0].rs2 : 5'd0), q[0].rd}));
        chk("rt_imm", d.imm, q[0].ssel ? 32'h0 : q[0].imm);
      end
    end else if (fresh) begin
      chk("reset_instr", instr, 32'h0);
      chk("reset_err", 32'(out_err), 32'h0);
    end
  end

  task automatic setv(input logic [3:0] o, input logic s, input logic [31:0] im,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] dd);
    op = o; ssel = s; imm = im; rs1 = a; rs2 = b; rd = dd; in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [3:0]  o;
    logic        s;
    logic [31:0] im;
    logic [4:0]  a, b, dd;
    logic [31:0] w;
    logic        e;
  } vec_t;

  vec_t       tbl[11];
  logic [3:0] r_ops[6];
  logic [3:0] i_ops[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ro;
    logic        rsel;
    logic [15:0] r16;
    logic [31:0] rim;

    tbl[0]  = '{4'd2,  1'b1, 32'h0,        5'd1,  5'd2,  5'd3,  32'h00221820, 1'b0};
    tbl[1]  = '{4'd2,  1'b0, 32'hFFFFFFFF, 5'd4,  5'd0,  5'd5,  32'h2085FFFF, 1'b0};
    tbl[2]  = '{4'd1,  1'b0, 32'h00010000, 5'd4,  5'd0,  5'd5,  32'h00000000, 1'b1};
    tbl[3]  = '{4'd6,  1'b0, 32'h00000001, 5'd1,  5'd0,  5'd2,  32'h00000000, 1'b1};
    tbl[4]  = '{4'd3,  1'b1, 32'h0,        5'd1,  5'd2,  5'd3,  32'h00000000, 1'b1};
    tbl[5]  = '{4'd7,  1'b0, 32'h00008000, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    tbl[6]  = '{4'd0,  1'b0, 32'hFFFFFFFF, 5'd1,  5'd0,  5'd1,  32'h00000000, 1'b1};
    tbl[7]  = '{4'd12, 1'b1, 32'h0,        5'd31, 5'd31, 5'd31, 32'h03FFF827, 1'b0};
    tbl[8]  = '{4'd1,  1'b0, 32'h0000FFFF, 5'd2,  5'd0,  5'd3,  32'h3443FFFF, 1'b0};
    tbl[9]  = '{4'd7,  1'b0, 32'hFFFF8000, 5'd0,  5'd0,  5'd1,  32'h28018000, 1'b0};
    tbl[10] = '{4'd6,  1'b1, 32'h0,        5'd1,  5'd2,  5'd3,  32'h00221822, 1'b0};
    r_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    i_ops = '{4'd0, 4'd1, 4'd2, 4'd7};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; ssel = 1'b0; imm = 32'h0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_valid", 32'(out_valid), 32'h0);
    chk("lit_rst_ready", 32'(in_ready), 32'h0);
    chk("lit_rst_count", 32'(enc_count), 32'h0);
    chk("lit_rst_instr", instr, 32'h0);
    rst = 1'b1;
    #1;
    chk("lit_ready_after_rst", 32'(in_ready), 32'h1);

    // Directed table, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      setv(tbl[i].o, tbl[i].s, tbl[i].im, tbl[i].a, tbl[i].b, tbl[i].dd);
      step();
      chk($sformatf("lit_word%0d", i), instr, tbl[i].w);
      chk($sformatf("lit_err%0d", i), 32'(out_err), 32'(tbl[i].e));
      if (i == 2) chk("lit_count_unchanged", 32'(enc_count), 32'h2);
    end
    in_valid = 1'b0;
    step();
    chk("lit_count_table", 32'(enc_count), 32'h6);

    // Backpressure: five offered, four fit.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setv(4'd2, 1'b1, 32'h0, 5'd0, 5'd0, 5'(i + 1));
      step();
      if (i == 3) chk("lit_full_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    chk("lit_full_head", instr, 32'h00000820);
    out_ready = 1'b1;
    repeat (4) step();
    chk("lit_drained_valid", 32'(out_valid), 32'h0);
    chk("lit_drained_ready", 32'(in_ready), 32'h1);

    // Random legal field sets, streaming.
    for (int i = 0; i < 40; i++) begin
      rsel = 1'($urandom_range(0, 1));
      r16  = 16'($urandom);
      if (rsel) begin
        ro  = r_ops[$urandom_range(0, 5)];
        rim = $urandom;
      end else begin
        ro  = i_ops[$urandom_range(0, 3)];
        rim = (ro == 4'd2 || ro == 4'd7) ? {{16{r16[15]}}, r16} : {16'h0, r16};
      end
      setv(ro, rsel, rim, 5'($urandom), 5'($urandom), 5'($urandom));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("lit_count_stream", 32'(enc_count), 32'd50);
    chk("lit_sat_count", 32'(s_enc_count), 32'd15);

    // Reset with words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setv(4'd1, 1'b1, 32'h0, 5'(i), 5'd1, 5'd2);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("lit_mid_rst_valid", 32'(out_valid), 32'h0);
    chk("lit_mid_rst_count", 32'(enc_count), 32'h0);
    chk("lit_mid_rst_sat", 32'(s_enc_count), 32'h0);
    rst = 1'b1;
    setv(4'd0, 1'b1, 32'h0, 5'd7, 5'd8, 5'd9);
    step();
    in_valid = 1'b0;
    chk("lit_post_rst_word", instr, 32'h00E84824);
    chk("lit_post_rst_count", 32'(enc_count), 32'h1);
    out_ready = 1'b1;
    step();
    chk("lit_post_rst_sole", 32'(out_valid), 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output queue entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of enc_count.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  field set present.
REQ-006 SHALL have port in_ready  output  1  field set accepted this edge when in_valid.
REQ-007 SHALL have port op  input  4  ALU operation code.
REQ-008 SHALL have port ssel  input  1  1 = register source (R-type), 0 = immediate source (I-type).
REQ-009 SHALL have port imm  input  32  immediate value, two's complement.
REQ-010 SHALL have ports rs1_id, rs2_id, rdst_id  input  5 each  register indices.
REQ-011 SHALL have port out_valid  output  1  instr/out_err valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes word this edge when out_valid.
REQ-013 SHALL have port instr  output  32  encoded instruction word.
REQ-014 SHALL have port out_err  output  1  word was unencodable and replaced by 0x00000000.
REQ-015 SHALL have port enc_count  output  CNT_W  count of successfully encoded words.

Function
REQ-016 SHALL accept a field set on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 iff rst=1 and queue occupancy < FIFO_DEPTH (no pop-while-full bypass).
REQ-017 SHALL place the encoded word in the queue on the accepting edge; out_valid SHALL rise the following cycle (latency 1).
REQ-018 SHALL present words in acceptance order; head SHALL advance on edges with out_valid=1 and out_ready=1; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-019 R-type (ssel=1): instr = {6'h00, rs1_id, rs2_id, rdst_id, 5'h00, funct}; funct AND=0x24, OR=0x25, ADD=0x20, SUB=0x22, SLT=0x2A, NOR=0x27.
REQ-020 I-type (ssel=0): instr = {opcode, rs1_id, rdst_id, imm[15:0]}; opcode ADD=0x08, SLT=0x0A, AND=0x0C, OR=0x0D; rs2_id ignored.
REQ-021 op codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12.
REQ-022 ADD/SLT immediates SHALL require imm[31:15] all equal; AND/OR immediates SHALL require imm[31:16]=0.
REQ-023 Any other op, SUB/NOR with ssel=0, or immediate out of range SHALL queue instr=0x00000000 with out_err=1.
REQ-024 enc_count SHALL increment on each accepted word with out_err=0 and saturate at all-ones.
REQ-025 instr and out_err SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While rst=0 at a rising edge: occupancy=0, out_valid=0, instr=0, out_err=0, enc_count=0; in_ready SHALL be 0 while rst=0.
REQ-027 Reset mid-operation SHALL discard all queued words; no partial word SHALL appear after release.

Structure
REQ-028 Package instr_pkg SHALL hold op codes, opcode/funct constants, field position constants, default FIFO_DEPTH.
REQ-029 Encoding SHALL be combinational ahead of one sub-module instr_fifo (synchronous FIFO, data 33 bits = {err, instr}, occupancy count).

Verification
REQ-030 op=2, ssel=1, rs1=1, rs2=2, rd=3 -> next cycle instr=0x00221820, out_err=0, enc_count=1.
REQ-031 op=2, ssel=0, rs1=4, rd=5, imm=-1 -> instr=0x2085FFFF; op=1, ssel=0, imm=0x10000 -> instr=0x00000000, out_err=1, enc_count unchanged.
REQ-032 out_ready=0, five consecutive valid inputs -> four accepted, in_ready=0 from the cycle after the fourth; out_ready=1 -> four words out in order, then in_ready=1.
REQ-033 Three words queued, rst=0 for one edge -> out_valid=0, enc_count=0 next cycle; first post-reset input emerges as sole head word.
REQ-034 Continuous out_ready=1 with random legal field sets -> one word per cycle, each round-trips through the team's instruction decoder to identical op/ssel/rs1/rs2/rdst and sign/zero-extended imm.
REQ-035 CNT_W=4, 17 legal inputs -> enc_count saturates at 15.
